// File: rtl/wrr_arbiter_pkg.sv
// rtl/wrr_arbiter_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Widest weight field the helpers handle; callers zero-extend into it
    localparam int WMAX_W = 16;

    // A zero weight still buys one beat so a misprogrammed port is never stuck
    function automatic logic [WMAX_W-1:0] eff_weight(input logic [WMAX_W-1:0] w);
        return (w == '0) ? WMAX_W'(1) : w;
    endfunction

    // Next port index after idx, wrapping from ports-1 back to 0
    function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned ports);
        return (idx >= ports - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_select.sv
// rtl/wrr_arbiter_rr_select.sv - rotating first-one picker using the doubled-vector subtract
module rr_select #(
    parameter  int PORTS  = 8,
    localparam int PORT_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]  request,
    input  logic [PORTS-1:0]  ptr,
    output logic [PORTS-1:0]  winner,
    output logic [PORT_W-1:0] winner_idx,
    output logic              found
);

    logic [2*PORTS-1:0] dbl;
    logic [2*PORTS-1:0] diff;
    logic [2*PORTS-1:0] hit;

    // Subtracting the one-hot pointer borrows up to the first request at or above it;
    // the doubled copy lets that borrow wrap past the top port
    assign dbl    = {request, request};
    assign diff   = dbl - {{PORTS{1'b0}}, ptr};
    assign hit    = dbl & ~diff;
    assign winner = hit[PORTS-1:0] | hit[2*PORTS-1:PORTS];
    assign found  = |request;

    // One-hot to index encoder
    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (winner[i]) begin
                winner_idx = winner_idx | PORT_W'(i);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with burst handshake; optional WRR_ARBITER_LOCK_EN adds a lock input
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter  int PORTS    = 8,
    parameter  int WEIGHT_W = 4,
    localparam int PORT_W   = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORTS-1:0]      request,
    input  logic [PORTS*WEIGHT_W-1:0] weight,
    input  logic                  ack,
    input  logic                  last,
`ifdef WRR_ARBITER_LOCK_EN
    input  logic                  lock,
`endif
    output logic [PORTS-1:0]      grant,
    output logic [PORT_W-1:0]     grant_port,
    output logic                  grant_valid,
    output logic [WEIGHT_W-1:0]   credit
);

    state_t              state;
    logic [PORT_W-1:0]   ptr_q;
    logic [PORT_W-1:0]   sel_base;
    logic [PORTS-1:0]    sel_ptr;
    logic [PORTS-1:0]    win;
    logic [PORT_W-1:0]   win_idx;
    logic                win_found;
    logic [WEIGHT_W-1:0] win_credit;
    logic [WEIGHT_W-1:0] w_arr [PORTS];
    logic                lock_en;
    logic                rel;

`ifdef WRR_ARBITER_LOCK_EN
    assign lock_en = lock;
`else
    assign lock_en = 1'b0;
`endif

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end

    // While owning, the search starts just past the owner so a release can regrant at the same edge
    always_comb begin
        sel_base = (state == OWN) ? PORT_W'(ptr_inc(32'(grant_port), PORTS)) : ptr_q;
        sel_ptr  = PORTS'(1) << sel_base;
    end

    rr_select #(
        .PORTS (PORTS)
    ) u_sel (
        .request    (request),
        .ptr        (sel_ptr),
        .winner     (win),
        .winner_idx (win_idx),
        .found      (win_found)
    );

    assign win_credit = WEIGHT_W'(eff_weight(WMAX_W'(w_arr[win_idx])));

    // Release priority: dropped request, then last beat, then credit exhausted; lock holds the burst open
    always_comb begin
        rel = 1'b0;
        if (!request[grant_port]) begin
            rel = 1'b1;
        end else if (ack && last && !lock_en) begin
            rel = 1'b1;
        end else if (ack && (credit == WEIGHT_W'(1)) && !lock_en) begin
            rel = 1'b1;
        end
    end

    // Ownership FSM with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr_q       <= '0;
            grant       <= '0;
            grant_port  <= '0;
            grant_valid <= 1'b0;
            credit      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= OWN;
                        grant       <= win;
                        grant_port  <= win_idx;
                        grant_valid <= 1'b1;
                        credit      <= win_credit;
                    end
                end
                OWN: begin
                    if (rel) begin
                        ptr_q <= sel_base;
                        if (win_found) begin
                            grant       <= win;
                            grant_port  <= win_idx;
                            grant_valid <= 1'b1;
                            credit      <= win_credit;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_port  <= '0;
                            grant_valid <= 1'b0;
                            credit      <= '0;
                        end
                    end else if (ack && (credit > WEIGHT_W'(1))) begin
                        credit <= credit - WEIGHT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
